// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared decimal-arithmetic definitions: radix constants, subtractor FSM
// states and a digit-validity helper.
package bcd_pkg;

    localparam logic [3:0] BCD_RADIX = 4'd10;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_COMP = 2'd2,
        ST_DONE = 2'd3
    } bcd_state_e;

    // True when a nibble is a legal decimal digit.
    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single decimal digit subtract with borrow: d = x - y - bi (mod 10).
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    logic [4:0] t;

    // 5-bit signed difference; a negative result wraps by adding the radix.
    always_comb begin
        t = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
        if (t[4]) begin
            d  = t[3:0] + BCD_RADIX;
            bo = 1'b1;
        end else begin
            d  = t[3:0];
            bo = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor, one digit per clock, LSD first.
// A first pass (SUB) forms a - b - bin; if that leaves a final borrow the
// register holds the ten's complement, and a second pass (COMP) forms
// 0 - raw to recover the magnitude, flagging the result negative.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic           borrow_q, borrow_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           neg_q, neg_d, err_q, err_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic [3:0]     dig_x, dig_y, dig_r;
    logic           dig_bo;
    logic           operand_bad;

    // Digit-slice operands: SUB uses the captured operands, COMP negates the
    // raw digit already sitting in diff.
    always_comb begin
        if (state_q == ST_COMP) begin
            dig_x = 4'd0;
            dig_y = diff_q[int'(idx_q)*4 +: 4];
        end else begin
            dig_x = a_q[int'(idx_q)*4 +: 4];
            dig_y = b_q[int'(idx_q)*4 +: 4];
        end
    end

    bcd_digit_sub u_digit (
        .x  (dig_x),
        .y  (dig_y),
        .bi (borrow_q),
        .d  (dig_r),
        .bo (dig_bo)
    );

    // Next-state and registered-output logic for the whole controller.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        operand_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(a[i*4 +: 4]) || !is_bcd_digit(b[i*4 +: 4])) begin
                operand_bad = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d = 1'b0;
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    diff_d = '0;
                    neg_d  = 1'b0;
                    idx_d  = '0;
                    if (operand_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        borrow_d = bin;
                        state_d  = ST_SUB;
                        busy_d   = 1'b1;
                    end
                end
            end
            ST_SUB, ST_COMP: begin
                diff_d[int'(idx_q)*4 +: 4] = dig_r;
                borrow_d = dig_bo;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (state_q == ST_SUB && dig_bo) begin
                        state_d  = ST_COMP;
                        borrow_d = 1'b0;
                    end else begin
                        neg_d   = (state_q == ST_COMP);
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: directed and random operations against
// an integer-arithmetic reference model.
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, neg, err;
    logic [W-1:0] diff;

    int checks   = 0;
    int failures = 0;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Reference: plain signed arithmetic on decimal values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] ediff, output logic eneg, output logic eerr,
                         output int elat);
        int v;
        eerr = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (ma[i*4 +: 4] > 4'd9 || mb[i*4 +: 4] > 4'd9) eerr = 1'b1;
        if (eerr) begin
            ediff = '0;
            eneg  = 1'b0;
            elat  = 1;
        end else begin
            v     = bcd2int(ma) - bcd2int(mb) - int'(mbin);
            eneg  = (v < 0);
            ediff = int2bcd(eneg ? -v : v);
            elat  = eneg ? 2 * DIGITS + 1 : DIGITS + 1;
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (edge 0),
    // returns at the negedge of cycle 1.
    task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin);
        a     = sa;
        b     = sb;
        bin   = sbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples each cycle from cycle 1 until done; optionally drives a stray
    // start with new operands in cycle inj_cyc. Returns at the done negedge.
    task automatic wait_done(input string tag, input logic [W-1:0] ediff, input logic eneg,
                             input logic eerr, input int elat, input int inj_cyc,
                             input logic [W-1:0] ia, input logic [W-1:0] ib);
        int cyc = 1;
        int busy_bad = 0;
        bit seen = 0;
        while (cyc <= 3 * DIGITS + 4 && !seen) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (cyc == inj_cyc) begin
                    a = ia;
                    b = ib;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, seen ? cyc : -1, elat);
        check({tag, "_busy_during"}, busy_bad, 0);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_diff"}, 32'(diff), 32'(ediff));
        check({tag, "_neg"}, 32'(neg), 32'(eneg));
        check({tag, "_err"}, 32'(err), 32'(eerr));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic rbin);
        logic [W-1:0] ediff;
        logic eneg, eerr;
        int elat;
        model(ra, rb, rbin, ediff, eneg, eerr, elat);
        start_op(ra, rb, rbin);
        wait_done(tag, ediff, eneg, eerr, elat, 0, '0, '0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_hold"}, {neg, err, 14'd0, diff}, {eneg, eerr, 14'd0, ediff});
    endtask

    initial begin
        logic [W-1:0] ediff, ra, rb;
        logic eneg, eerr;
        int elat, quiet_bad;

        // Reset
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, neg, err, 12'd0, diff}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        run_op("t1_pos", 16'h5327, 16'h1458, 1'b0);
        run_op("t2_neg", 16'h1458, 16'h5327, 1'b0);
        run_op("t3_eq_bin", 16'h0042, 16'h0042, 1'b1);
        run_op("t3_eq_zero", 16'h0042, 16'h0042, 1'b0);
        run_op("t4_max", 16'h9999, 16'h0000, 1'b1);
        run_op("t4_min", 16'h0000, 16'h9999, 1'b0);
        run_op("t5_err", 16'h12A4, 16'h0001, 1'b0);
        run_op("t5_clear", 16'h0100, 16'h0001, 1'b0);

        // Stray start in cycle 2 is ignored
        model(16'h5327, 16'h1458, 1'b0, ediff, eneg, eerr, elat);
        start_op(16'h5327, 16'h1458, 1'b0);
        wait_done("t6_ignore", ediff, eneg, eerr, elat, 2, 16'h0001, 16'h0999);
        @(negedge clk);
        check("t6_ignore_idle", {busy, done}, 0);

        // Reset mid-operation aborts without done
        start_op(16'h1458, 16'h5327, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_abort_outputs", {busy, done, neg, err, 12'd0, diff}, 32'd0);
        quiet_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        check("t6_abort_quiet", quiet_bad, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("t6_after_reset", 16'h2000, 16'h0001, 1'b1);

        // Back-to-back: start during the DONE cycle
        model(16'h0750, 16'h0251, 1'b0, ediff, eneg, eerr, elat);
        start_op(16'h0750, 16'h0251, 1'b0);
        wait_done("t6_b2b_first", ediff, eneg, eerr, elat, 0, '0, '0);
        model(16'h0251, 16'h0750, 1'b1, ediff, eneg, eerr, elat);
        start_op(16'h0251, 16'h0750, 1'b1);
        wait_done("t6_b2b_second", ediff, eneg, eerr, elat, 0, '0, '0);
        @(negedge clk);

        // Random operations, occasionally with an illegal digit
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
            run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
